hack_cpu_ctrl: RTL and testbench



---
 rtl/hack_pkg.sv | 27 ++
 rtl/hack_cpu_ctrl_if.sv | 32 +++
 rtl/ALU.sv | 33 +++
 rtl/hack_cpu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the Hack control core.
//   - WORD / PC_W   : data word width and program-counter width
//   - state_t       : control FSM states (FETCH / MREAD / EXEC)
//   - IR field bit positions for C-instructions
//     (111a cccccc ddd jjj)
package hack_pkg;

    localparam int WORD = 16;
    localparam int PC_W = 15;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_MREAD = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // Instruction field positions
    localparam int C_FLAG  = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// hack_cpu_ctrl_if: bundle of the instruction, data-memory and debug signals
// of the Hack control core.
//   master : the core (consumes instructions and read data, drives requests,
//            write strobe/data, pc and debug views)
//   slave  : the surrounding instruction/data memory system
interface hack_cpu_ctrl_if;
    import hack_pkg::*;

    logic [WORD-1:0] instr;
    logic            instr_valid;
    logic            instr_ready;
    logic [WORD-1:0] inM;
    logic            inM_valid;
    logic            mem_req;
    logic [PC_W-1:0] addressM;
    logic [WORD-1:0] outM;
    logic            writeM;
    logic [PC_W-1:0] pc;
    logic [WORD-1:0] dbg_a;
    logic [WORD-1:0] dbg_d;

    modport master (
        input  instr, instr_valid, inM, inM_valid,
        output instr_ready, mem_req, addressM, outM, writeM, pc, dbg_a, dbg_d
    );

    modport slave (
        output instr, instr_valid, inM, inM_valid,
        input  instr_ready, mem_req, addressM, outM, writeM, pc, dbg_a, dbg_d
    );

endinterface

// File: rtl/ALU.sv
// ALU: the Hack arithmetic/logic unit.
//   x, y            : 16-bit operands
//   zx nx zy ny f no: zero/negate x, zero/negate y, add (1) or and (0),
//                     negate output
//   out             : result
//   zr              : out == 0
//   ng              : out < 0 (two's complement)
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    assign x_z   = zx ? 16'h0000 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'h0000 : y;
    assign y_n   = ny ? ~y_z : y_z;
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign out   = no ? ~f_out : f_out;
    assign zr    = (out == 16'h0000);
    assign ng    = out[15];

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack control core.
// Accepts instructions over instr/instr_valid/instr_ready, fetches M over
// mem_req/inM_valid for C-instructions with a=1, drives the ALU from the
// decoded comp field and updates A, D, PC and memory in a single EXEC cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : hack_cpu_ctrl_if.master (instruction, data memory, pc, debug)
module hack_cpu_ctrl
    import hack_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    hack_cpu_ctrl_if.master bus
);

    state_t          state_q, state_d;
    logic [WORD-1:0] a_q, a_d;
    logic [WORD-1:0] d_q, d_d;
    logic [WORD-1:0] m_q, m_d;
    logic [WORD-1:0] ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            accept;
    logic            is_c;
    logic [5:0]      comp;
    logic [2:0]      dest;
    logic [2:0]      jump;
    logic [WORD-1:0] alu_y;
    logic [WORD-1:0] alu_out;
    logic            alu_zr;
    logic            alu_ng;
    logic            jump_taken;
    logic            unused_ir_bits;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign accept = bus.instr_valid && bus.instr_ready;
    assign is_c   = ir_q[C_FLAG];
    assign comp   = ir_q[COMP_HI:COMP_LO];
    assign dest   = ir_q[DEST_HI:DEST_LO];
    assign jump   = ir_q[JUMP_HI:JUMP_LO];

    // Bits 14:13 of a C-instruction are fixed ones and carry no meaning.
    assign unused_ir_bits = ^ir_q[14:13];

    assign alu_y = ir_q[A_BIT] ? m_q : a_q;

    ALU u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (comp[5]),
        .nx  (comp[4]),
        .zy  (comp[3]),
        .ny  (comp[2]),
        .f   (comp[1]),
        .no  (comp[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // jjj = {lt, eq, gt}; A-instructions never jump.
    assign jump_taken = is_c && ((jump[2] && alu_ng) ||
                                 (jump[1] && alu_zr) ||
                                 (jump[0] && !alu_ng && !alu_zr));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    if (bus.instr[C_FLAG] && bus.instr[A_BIT]) begin
                        state_d = ST_MREAD;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_MREAD: begin
                // No timeout: a read that never completes stalls the core.
                if (bus.inM_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.mem_req     = 1'b0;
        bus.writeM      = 1'b0;
        case (state_q)
            // Reset gates ready so nothing is accepted during reset.
            ST_FETCH: bus.instr_ready = !reset;
            ST_MREAD: bus.mem_req     = 1'b1;
            ST_EXEC:  bus.writeM      = is_c && dest[0];
            default: ;
        endcase
    end

    assign bus.addressM = a_q[PC_W-1:0];
    assign bus.outM     = alu_out;
    assign bus.pc       = pc_q;
    assign bus.dbg_a    = a_q;
    assign bus.dbg_d    = d_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // All EXEC updates read the pre-update A/D/PC, so AM=..., jumps to A
    // with A as a destination, and writes at the old A all behave.
    // ------------------------------------------------------------------
    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        m_d  = m_q;
        ir_d = ir_q;
        pc_d = pc_q;
        case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    ir_d = bus.instr;
                end
            end
            ST_MREAD: begin
                if (bus.inM_valid) begin
                    m_d = bus.inM;
                end
            end
            ST_EXEC: begin
                if (!is_c) begin
                    a_d = ir_q;
                end else begin
                    if (dest[2]) a_d = alu_out;
                    if (dest[1]) d_d = alu_out;
                end
                // pc + 1 wraps naturally within PC_W bits.
                pc_d = jump_taken ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            d_q  <= '0;
            m_q  <= '0;
            ir_q <= '0;
            pc_q <= '0;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            m_q  <= m_d;
            ir_q <= ir_d;
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: self-checking bench for hack_cpu_ctrl.
// Directed table of the reference program, randomized instruction stream
// checked against an instruction-level model, and a reset-during-read sequence.
module tb_hack_cpu_ctrl;
    import hack_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction-level model state
    logic [15:0] ma, md;
    logic [14:0] mpc;
    int          e_wr;
    logic [14:0] e_waddr;
    logic [15:0] e_wdata;

    // Observations of one transaction
    int          obs_cyc, obs_mreq, obs_wr;
    logic [14:0] obs_waddr;
    logic [15:0] obs_wdata;

    typedef struct {
        logic [15:0] instr;
        int          mdelay;
        logic [15:0] mdata;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [14:0] epc;
        int          ewr;
        logic [14:0] ewaddr;
        logic [15:0] ewdata;
    } vec_t;

    vec_t       vecs[19];
    logic [5:0] comps[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hack comp mnemonics evaluated arithmetically (x = D, y = A or M).
    function automatic logic [15:0] hack_comp(input logic [5:0] c, input logic [15:0] x,
                                              input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hDEAD;
        endcase
    endfunction

    task automatic model_step(input logic [15:0] w, input logic [15:0] mdata);
        logic [15:0] y, r;
        logic        jmp;
        logic [14:0] next_pc;
        e_wr    = 0;
        e_waddr = ma[14:0];
        e_wdata = 16'h0;
        if (!w[15]) begin
            ma  = w;
            mpc = mpc + 15'd1;
        end else begin
            y = w[12] ? mdata : ma;
            r = hack_comp(w[11:6], md, y);
            case (w[2:0])
                3'd0: jmp = 1'b0;
                3'd1: jmp = $signed(r) > 0;
                3'd2: jmp = (r == 16'd0);
                3'd3: jmp = $signed(r) >= 0;
                3'd4: jmp = $signed(r) < 0;
                3'd5: jmp = (r != 16'd0);
                3'd6: jmp = $signed(r) <= 0;
                default: jmp = 1'b1;
            endcase
            next_pc = jmp ? ma[14:0] : mpc + 15'd1;
            if (w[3]) begin
                e_wr    = 1;
                e_wdata = r;
            end
            if (w[5]) ma = r;
            if (w[4]) md = r;
            mpc = next_pc;
        end
    endtask

    task automatic run_instr(input logic [15:0] w, input int mdelay, input logic [15:0] mdata);
        int waited = 0;
        int guard  = 0;
        obs_cyc = 0; obs_mreq = 0; obs_wr = 0; obs_waddr = '0; obs_wdata = '0;
        while (!bus.instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.instr_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        do begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.instr       = 16'($urandom);
            obs_cyc++;
            if (bus.mem_req) begin
                obs_mreq++;
                if (waited >= mdelay) begin
                    bus.inM_valid = 1'b1;
                    bus.inM       = mdata;
                end else begin
                    bus.inM_valid = 1'b0;
                    bus.inM       = 16'($urandom);
                    waited++;
                end
            end else begin
                // Stray valid pulses outside a read must be ignored.
                bus.inM_valid = 1'($urandom_range(0, 1));
                bus.inM       = 16'($urandom);
            end
            if (bus.writeM) begin
                obs_wr++;
                obs_waddr = bus.addressM;
                obs_wdata = bus.outM;
            end
        end while (!bus.instr_ready && obs_cyc < 60);
        if (!bus.instr_ready) chk("done_timeout", 32'd0, 32'd1);
        bus.inM_valid = 1'b0;
    endtask

    task automatic check_txn(input int idx, input logic [15:0] w, input int mdelay,
                             input logic [15:0] ea, input logic [15:0] ed, input logic [14:0] epc,
                             input int ewr, input logic [14:0] ewaddr, input logic [15:0] ewdata);
        int ecyc;
        int emreq;
        ecyc  = (w[15] && w[12]) ? 3 + mdelay : 2;
        emreq = (w[15] && w[12]) ? 1 + mdelay : 0;
        chk("dbg_a", bus.dbg_a, ea);
        chk("dbg_d", bus.dbg_d, ed);
        chk("pc", bus.pc, epc);
        chk("write_count", obs_wr, ewr);
        if (ewr != 0) begin
            chk("write_addr", obs_waddr, ewaddr);
            chk("write_data", obs_wdata, ewdata);
        end
        chk("cycles", obs_cyc, ecyc);
        chk("mem_req_cycles", obs_mreq, emreq);
        $display("txn %0d instr=%04h a=%04h d=%04h pc=%04h cyc=%0d wr=%0d",
                 idx, w, bus.dbg_a, bus.dbg_d, bus.pc, obs_cyc, obs_wr);
    endtask

    initial begin
        logic [15:0] w;
        int          dly;
        logic [15:0] mdat;

        vecs = '{
            '{16'h0011, 0, 16'h0000, 16'h0011, 16'h0000, 15'h0001, 0, 15'h0000, 16'h0000},
            '{16'hEC10, 0, 16'h0000, 16'h0011, 16'h0011, 15'h0002, 0, 15'h0000, 16'h0000},
            '{16'h0003, 0, 16'h0000, 16'h0003, 16'h0011, 15'h0003, 0, 15'h0000, 16'h0000},
            '{16'hE090, 0, 16'h0000, 16'h0003, 16'h0014, 15'h0004, 0, 15'h0000, 16'h0000},
            '{16'h0064, 0, 16'h0000, 16'h0064, 16'h0014, 15'h0005, 0, 15'h0000, 16'h0000},
            '{16'hE308, 0, 16'h0000, 16'h0064, 16'h0014, 15'h0006, 1, 15'h0064, 16'h0014},
            '{16'h0064, 0, 16'h0000, 16'h0064, 16'h0014, 15'h0007, 0, 15'h0000, 16'h0000},
            '{16'hFC10, 3, 16'h1234, 16'h0064, 16'h1234, 15'h0008, 0, 15'h0000, 16'h0000},
            '{16'h0020, 0, 16'h0000, 16'h0020, 16'h1234, 15'h0009, 0, 15'h0000, 16'h0000},
            '{16'hEA87, 0, 16'h0000, 16'h0020, 16'h1234, 15'h0020, 0, 15'h0000, 16'h0000},
            '{16'h0014, 0, 16'h0000, 16'h0014, 16'h1234, 15'h0021, 0, 15'h0000, 16'h0000},
            '{16'hEC10, 0, 16'h0000, 16'h0014, 16'h0014, 15'h0022, 0, 15'h0000, 16'h0000},
            '{16'hE302, 0, 16'h0000, 16'h0014, 16'h0014, 15'h0023, 0, 15'h0000, 16'h0000},
            '{16'h7FFF, 0, 16'h0000, 16'h7FFF, 16'h0014, 15'h0024, 0, 15'h0000, 16'h0000},
            '{16'hEA87, 0, 16'h0000, 16'h7FFF, 16'h0014, 15'h7FFF, 0, 15'h0000, 16'h0000},
            '{16'h0005, 0, 16'h0000, 16'h0005, 16'h0014, 15'h0000, 0, 15'h0000, 16'h0000},
            '{16'hFDE8, 0, 16'h00FF, 16'h0100, 16'h0014, 15'h0001, 1, 15'h0005, 16'h0100},
            '{16'hE327, 0, 16'h0000, 16'h0014, 16'h0014, 15'h0100, 0, 15'h0000, 16'h0000},
            '{16'hEA82, 0, 16'h0000, 16'h0014, 16'h0014, 15'h0014, 0, 15'h0000, 16'h0000}
        };
        comps = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                  6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                  6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.inM         = 16'h0000;
        bus.inM_valid   = 1'b0;
        reset           = 1'b1;
        ma = '0; md = '0; mpc = '0;

        // Reset state while reset is held
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.instr_ready, 1'b0);
        chk("rst_pc", bus.pc, 15'h0000);
        chk("rst_a", bus.dbg_a, 16'h0000);
        chk("rst_d", bus.dbg_d, 16'h0000);
        chk("rst_writeM", bus.writeM, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.instr_ready, 1'b1);

        // Directed program
        for (int i = 0; i < 19; i++) begin
            model_step(vecs[i].instr, vecs[i].mdata);
            run_instr(vecs[i].instr, vecs[i].mdelay, vecs[i].mdata);
            check_txn(i, vecs[i].instr, vecs[i].mdelay, vecs[i].ea, vecs[i].ed, vecs[i].epc,
                      vecs[i].ewr, vecs[i].ewaddr, vecs[i].ewdata);
        end

        // Randomized instruction stream against the model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                w = {1'b0, 15'($urandom)};
            end else begin
                w = {3'b111, 1'($urandom_range(0, 1)), comps[$urandom_range(0, 17)],
                     3'($urandom), 3'($urandom)};
            end
            dly  = $urandom_range(0, 3);
            mdat = 16'($urandom);
            model_step(w, mdat);
            run_instr(w, dly, mdat);
            check_txn(100 + i, w, dly, ma, md, mpc, e_wr, e_waddr, e_wdata);
        end

        // Reset while waiting in MREAD, then a late inM_valid
        begin
            int guard = 0;
            while (!bus.instr_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        bus.instr       = 16'hFC10;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.inM_valid   = 1'b0;
        @(negedge clk);
        chk("mread_mem_req", bus.mem_req, 1'b1);
        chk("mread_ready", bus.instr_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", bus.mem_req, 1'b0);
        chk("mid_rst_pc", bus.pc, 15'h0000);
        chk("mid_rst_a", bus.dbg_a, 16'h0000);
        chk("mid_rst_d", bus.dbg_d, 16'h0000);
        chk("mid_rst_writeM", bus.writeM, 1'b0);
        chk("mid_rst_ready", bus.instr_ready, 1'b0);
        @(negedge clk);
        reset         = 1'b0;
        bus.inM_valid = 1'b1;
        bus.inM       = 16'hBEEF;
        #1;
        chk("late_ready", bus.instr_ready, 1'b1);
        chk("late_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        bus.inM_valid = 1'b0;
        chk("late_d", bus.dbg_d, 16'h0000);
        chk("late_pc", bus.pc, 15'h0000);
        chk("late_writeM", bus.writeM, 1'b0);
        chk("late_fetch", bus.instr_ready, 1'b1);

        // Normal operation resumes from the cleared state
        ma = '0; md = '0; mpc = '0;
        model_step(16'h0042, 16'h0000);
        run_instr(16'h0042, 0, 16'h0000);
        check_txn(900, 16'h0042, 0, ma, md, mpc, e_wr, e_waddr, e_wdata);
        model_step(16'hE7D8, 16'h0000);
        run_instr(16'hE7D8, 0, 16'h0000);
        check_txn(901, 16'hE7D8, 0, ma, md, mpc, e_wr, e_waddr, e_wdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
